// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issuer: opcodes, FSM states and the 7-segment table.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CAPT  = 2'd3
  } state_t;

  // Active-high segment patterns, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [7:0] seg_encode(input logic [3:0] val, input logic dp,
                                            input logic active_low);
    logic [7:0] raw;
    raw = {dp, SEG_HEX[val]};
    return active_low ? ~raw : raw;
  endfunction

endpackage

// File: rtl/alu_issuer_debounce.sv
// GO button conditioning: 2-FF synchronizer, stability counter, rising-edge press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;

  // r_cnt counts consecutive cycles the synchronized input disagrees with the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= 2'b00;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_level_d <= r_level;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/alu_issuer.sv
// Drives the lab-board ALU from switches on a debounced GO press and captures its result.
// Optional macro ALU_SWEEP_EN: one press runs all 8 opcodes into a result register file.
module alu_issuer
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ALU_LAT         = 1,
  parameter bit SEG_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_a,
  input  logic [3:0] sw_b,
  input  logic [2:0] sw_op,
  input  logic       btn_go,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_ctrl,
  input  logic [3:0] alu_res,
  input  logic       alu_car,
  input  logic       alu_of,
  output logic       busy,
  output logic       res_valid,
  output logic [3:0] res_q,
  output logic       car_q,
  output logic       of_q,
  output logic [7:0] seg0
);

  localparam logic [3:0] WAIT_INIT = 4'(ALU_LAT - 1);
  localparam logic [7:0] SEG_BLANK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  state_t     r_state;
  logic [3:0] r_wait_cnt;
  logic [3:0] r_alu_a;
  logic [3:0] r_alu_b;
  logic [2:0] r_alu_ctrl;
  logic [3:0] r_res;
  logic       r_car;
  logic       r_of;
  logic       r_res_valid;
  logic       r_shown;
  logic       w_press;
  logic [5:0] w_entry;

`ifdef ALU_SWEEP_EN
  logic [5:0] r_rf [8];
`endif

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_go),
    .o_press (w_press)
  );

  // Results are latched on the WAIT->CAPT edge so res_valid and res_q appear together in CAPT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_ctrl  <= '0;
      r_res       <= '0;
      r_car       <= 1'b0;
      r_of        <= 1'b0;
      r_res_valid <= 1'b0;
      r_shown     <= 1'b0;
`ifdef ALU_SWEEP_EN
      // NOTE: the register file is reset like every other register so a post-reset read is 0.
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments only, so every register samples pre-edge values.
      r_res_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_press) begin
            r_alu_a <= sw_a;
            r_alu_b <= sw_b;
`ifdef ALU_SWEEP_EN
            r_alu_ctrl <= OP_ADD;
`else
            r_alu_ctrl <= sw_op;
`endif
            r_state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          r_wait_cnt <= WAIT_INIT;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_res       <= alu_res;
            r_car       <= alu_car;
            r_of        <= alu_of;
            r_res_valid <= 1'b1;
            r_shown     <= 1'b1;
`ifdef ALU_SWEEP_EN
            r_rf[r_alu_ctrl] <= {alu_of, alu_car, alu_res};
`endif
            r_state <= ST_CAPT;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        ST_CAPT: begin
`ifdef ALU_SWEEP_EN
          if (r_alu_ctrl == OP_EQ) begin
            r_state <= ST_IDLE;
          end else begin
            r_alu_ctrl <= r_alu_ctrl + 3'd1;
            r_state    <= ST_DRIVE;
          end
`else
          r_state <= ST_IDLE;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_SWEEP_EN
  assign w_entry = (r_state == ST_IDLE) ? r_rf[sw_op] : {r_of, r_car, r_res};
`else
  assign w_entry = {r_of, r_car, r_res};
`endif

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_ctrl  = r_alu_ctrl;
  assign busy      = (r_state != ST_IDLE);
  assign res_valid = r_res_valid;
  assign res_q     = w_entry[3:0];
  assign car_q     = w_entry[4];
  assign of_q      = w_entry[5];
  assign seg0      = r_shown ? seg_encode(w_entry[3:0], w_entry[5], SEG_ACTIVE_LOW) : SEG_BLANK;

endmodule
